// File: rtl/dmem_ctrl.sv
// dmem_ctrl: word-organised data memory with programmable latency; DMEM_MISALIGN_TRAP_EN traps misaligned addresses
module dmem_ctrl #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] ALUresult,
    input  logic [31:0] Write_Data,
    input  logic [3:0]  Byte_En,
    output logic [31:0] Read_Data,
    output logic        Mem_Ready,
    output logic        Mem_Busy,
    output logic        Mem_Err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [31:0]   mem [DEPTH];
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [AW-1:0] idx;
    logic          out_of_range;
    logic          misalign;
    logic          err_now;
    logic          done_now;
    logic          accept;
    logic          store_en;

    assign idx          = addr_q[AW+1:2];
    assign out_of_range = |addr_q[31:AW+2];
`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign = |addr_q[1:0];
`else
    logic unused_lsb;
    assign unused_lsb = ^addr_q[1:0];
    assign misalign   = 1'b0;
`endif
    assign err_now  = out_of_range | (rd_q & wr_q) | misalign;
    assign done_now = (state_q == ACCESS) && (cnt_q == '0);
    // DONE samples requests too, so a back-to-back access is captured on the edge Mem_Ready drops
    assign accept   = (state_q != ACCESS) && (MemRead | MemWrite);
    assign store_en = done_now & wr_q & ~rd_q & ~err_now;

    assign Read_Data = rdata_q;
    assign Mem_Ready = (state_q == DONE);
    assign Mem_Busy  = (state_q != IDLE);
    assign Mem_Err   = err_q;

    // Next-state, request capture and completion results
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        if (accept) begin
            state_d = ACCESS;
            cnt_d   = CNT_INIT;
            addr_d  = ALUresult;
            wdata_d = Write_Data;
            be_d    = Byte_En;
            rd_d    = MemRead;
            wr_d    = MemWrite;
        end else if (state_q == ACCESS) begin
            cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
            state_d = (cnt_q != '0) ? ACCESS : DONE;
        end else begin
            state_d = IDLE;
        end
        err_d   = done_now & err_now;
        rdata_d = (done_now & rd_q) ? (err_now ? 32'h0 : mem[idx]) : rdata_q;
    end

    // Control and result registers; reset aborts any access in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Byte-lane store into the unreset memory array
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (store_en && be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed vector bench for dmem_ctrl (DEPTH=256, LATENCY=2)
module tb_dmem_ctrl;
    localparam int LAT = 2;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam logic        R12_ERR  = 1'b1;
    localparam logic [31:0] R12_DATA = 32'h0;
`else
    localparam logic        R12_ERR  = 1'b0;
    localparam logic [31:0] R12_DATA = 32'hDEADAAEF;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [31:0] ALUresult, Write_Data;
    logic [3:0]  Byte_En;
    logic [31:0] Read_Data;
    logic        Mem_Ready, Mem_Busy, Mem_Err;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        err;
        logic        chk_rd;
        logic [31:0] rdata;
    } vec_t;
    vec_t v [16];

    dmem_ctrl #(.DEPTH(256), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .ALUresult(ALUresult), .Write_Data(Write_Data), .Byte_En(Byte_En),
        .Read_Data(Read_Data), .Mem_Ready(Mem_Ready), .Mem_Busy(Mem_Busy), .Mem_Err(Mem_Err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        MemRead = r; MemWrite = w; ALUresult = a; Write_Data = d; Byte_En = b;
        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!Mem_Ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        int n;
        v[0]  = '{1'b0, 1'b1, 32'h010, 32'hDEADBEEF, 4'hF, 1'b0, 1'b1, 32'h0};
        v[1]  = '{1'b1, 1'b0, 32'h010, 32'h0,        4'h0, 1'b0, 1'b1, 32'hDEADBEEF};
        v[2]  = '{1'b0, 1'b1, 32'h010, 32'h0000AA00, 4'h2, 1'b0, 1'b1, 32'hDEADBEEF};
        v[3]  = '{1'b1, 1'b0, 32'h010, 32'h0,        4'h0, 1'b0, 1'b1, 32'hDEADAAEF};
        v[4]  = '{1'b1, 1'b0, 32'h012, 32'h0,        4'h0, R12_ERR, 1'b1, R12_DATA};
        v[5]  = '{1'b0, 1'b1, 32'h000, 32'h11111111, 4'hF, 1'b0, 1'b1, R12_DATA};
        v[6]  = '{1'b1, 1'b0, 32'h000, 32'h0,        4'h0, 1'b0, 1'b1, 32'h11111111};
        v[7]  = '{1'b0, 1'b1, 32'h400, 32'h12345678, 4'hF, 1'b1, 1'b1, 32'h11111111};
        v[8]  = '{1'b1, 1'b0, 32'h000, 32'h0,        4'h0, 1'b0, 1'b1, 32'h11111111};
        v[9]  = '{1'b1, 1'b0, 32'h800, 32'h0,        4'h0, 1'b1, 1'b1, 32'h0};
        v[10] = '{1'b1, 1'b1, 32'h010, 32'h0,        4'hF, 1'b1, 1'b0, 32'h0};
        v[11] = '{1'b1, 1'b0, 32'h010, 32'h0,        4'h0, 1'b0, 1'b1, 32'hDEADAAEF};
        v[12] = '{1'b0, 1'b1, 32'h000, 32'hFFFFFFFF, 4'h0, 1'b0, 1'b1, 32'hDEADAAEF};
        v[13] = '{1'b1, 1'b0, 32'h000, 32'h0,        4'h0, 1'b0, 1'b1, 32'h11111111};
        v[14] = '{1'b0, 1'b1, 32'h000, 32'hFFFFFFFF, 4'h9, 1'b0, 1'b1, 32'h11111111};
        v[15] = '{1'b1, 1'b0, 32'h000, 32'h0,        4'h0, 1'b0, 1'b1, 32'hFF1111FF};

        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
        ALUresult = '0; Write_Data = '0; Byte_En = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdata", Read_Data, 32'h0);
        chk("rst_ready", 32'(Mem_Ready), 32'h0);
        chk("rst_busy", 32'(Mem_Busy), 32'h0);
        chk("rst_err", 32'(Mem_Err), 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            start(v[i].rd, v[i].wr, v[i].addr, v[i].wd, v[i].be);
            chk($sformatf("v%0d_busy", i), 32'(Mem_Busy), 32'h1);
            wait_ready(n);
            chk($sformatf("v%0d_latency", i), 32'(n), 32'(LAT));
            chk($sformatf("v%0d_err", i), 32'(Mem_Err), 32'(v[i].err));
            if (v[i].chk_rd) chk($sformatf("v%0d_rdata", i), Read_Data, v[i].rdata);
            @(posedge clk); #1;
            chk($sformatf("v%0d_ready_drop", i), {30'h0, Mem_Ready, Mem_Err}, 32'h0);
        end

        start(1'b1, 1'b0, 32'h000, 32'h0, 4'h0);
        MemRead = 1'b1; ALUresult = 32'h010;
        @(posedge clk); #1;
        MemRead = 1'b0;
        wait_ready(n);
        chk("busy_ign_latency", 32'(n), 32'(LAT - 1));
        chk("busy_ign_rdata", Read_Data, 32'hFF1111FF);
        @(posedge clk); #1;
        chk("busy_ign_idle", {30'h0, Mem_Busy, Mem_Ready}, 32'h0);

        start(1'b0, 1'b1, 32'h010, 32'h0, 4'hF);
        chk("abort_busy", 32'(Mem_Busy), 32'h1);
        reset = 1'b1;
        #1;
        chk("abort_rdata", Read_Data, 32'h0);
        chk("abort_flags", {29'h0, Mem_Ready, Mem_Busy, Mem_Err}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        start(1'b1, 1'b0, 32'h010, 32'h0, 4'h0);
        wait_ready(n);
        chk("abort_latency", 32'(n), 32'(LAT));
        chk("abort_no_store", Read_Data, 32'hDEADAAEF);
        chk("abort_err", 32'(Mem_Err), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
